// File: rtl/cu_pkg.sv
// Shared control-unit definitions: control-word field positions, control-unit state
// encodings, dispatch FSM states and the decoded field bundle.
package cu_pkg;

    localparam int CW_WIDTH     = 33;
    localparam int K_WIDTH      = 64;
    localparam int STATUS_WIDTH = 5;

    localparam int CW_ALU_EN      = 32;
    localparam int CW_ALU_BS      = 31;
    localparam int CW_ALU_FS_HI   = 30;
    localparam int CW_ALU_FS_LO   = 26;
    localparam int CW_RF_B_EN     = 25;
    localparam int CW_SA_HI       = 24;
    localparam int CW_SA_LO       = 20;
    localparam int CW_SB_HI       = 19;
    localparam int CW_SB_LO       = 15;
    localparam int CW_WA_HI       = 14;
    localparam int CW_WA_LO       = 10;
    localparam int CW_RF_W        = 9;
    localparam int CW_RAM_EN      = 8;
    localparam int CW_RAM_W       = 7;
    localparam int CW_PC_EN       = 6;
    localparam int CW_PC_FS_HI    = 5;
    localparam int CW_PC_FS_LO    = 4;
    localparam int CW_PC_IN_SEL   = 3;
    localparam int CW_STATUS_LOAD = 2;
    localparam int CW_NS_HI       = 1;
    localparam int CW_NS_LO       = 0;

    // Control-unit state seen by the decoders; FETCH is the post-reset default.
    localparam logic [1:0] CU_FETCH = 2'b00;
    localparam logic [1:0] CU_EXEC1 = 2'b01;
    localparam logic [1:0] CU_EXEC2 = 2'b10;
    localparam logic [1:0] CU_EXEC3 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } fsm_t;

    typedef struct packed {
        logic       alu_en;
        logic       alu_bs;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] wa;
        logic       rf_w;
        logic       ram_en;
        logic       ram_w;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_in_sel;
        logic       status_load;
        logic [1:0] ns;
    } cw_fields_t;

    // True when more than one databus driver is enabled at once.
    function automatic logic multi_bus_enable(input logic [3:0] en);
        return $countones(en) > 1;
    endfunction

endpackage

// File: rtl/control_word_dispatch_if.sv
// Decoder-side link: control word + literal handshake, and the state/status fed back
// to the decoders.
interface control_word_dispatch_if;
    import cu_pkg::*;

    logic [CW_WIDTH-1:0]     cw_in;
    logic [K_WIDTH-1:0]      k_in;
    logic                    cw_valid;
    logic                    cw_ready;
    logic [1:0]              state;
    logic [STATUS_WIDTH-1:0] status;

    modport master (output cw_in, k_in, cw_valid, input cw_ready, state, status);
    modport slave  (input cw_in, k_in, cw_valid, output cw_ready, state, status);

endinterface

// File: rtl/cw_field_split.sv
// Purely combinational slicing of a 33-bit control word into named fields.
module cw_field_split
    import cu_pkg::*;
(
    input  logic [CW_WIDTH-1:0] cw,
    output cw_fields_t          fields
);

    always_comb begin
        fields.alu_en      = cw[CW_ALU_EN];
        fields.alu_bs      = cw[CW_ALU_BS];
        fields.alu_fs      = cw[CW_ALU_FS_HI:CW_ALU_FS_LO];
        fields.rf_b_en     = cw[CW_RF_B_EN];
        fields.sa          = cw[CW_SA_HI:CW_SA_LO];
        fields.sb          = cw[CW_SB_HI:CW_SB_LO];
        fields.wa          = cw[CW_WA_HI:CW_WA_LO];
        fields.rf_w        = cw[CW_RF_W];
        fields.ram_en      = cw[CW_RAM_EN];
        fields.ram_w       = cw[CW_RAM_W];
        fields.pc_en       = cw[CW_PC_EN];
        fields.pc_fs       = cw[CW_PC_FS_HI:CW_PC_FS_LO];
        fields.pc_in_sel   = cw[CW_PC_IN_SEL];
        fields.status_load = cw[CW_STATUS_LOAD];
        fields.ns          = cw[CW_NS_HI:CW_NS_LO];
    end

endmodule

// File: rtl/control_word_dispatch.sv
// Accepts decoded control words, registers them into datapath controls, owns the
// control-unit state and status registers, and gates write strobes across stalls.
module control_word_dispatch
    import cu_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    control_word_dispatch_if.slave  dec,
    input  logic                    dp_stall,
    input  logic [STATUS_WIDTH-1:0] alu_status,
    output logic                    alu_en,
    output logic                    alu_bs,
    output logic [4:0]              alu_fs,
    output logic                    rf_b_en,
    output logic [4:0]              rf_sa,
    output logic [4:0]              rf_sb,
    output logic [4:0]              rf_wa,
    output logic                    rf_w,
    output logic                    ram_en,
    output logic                    ram_w,
    output logic                    pc_en,
    output logic [1:0]              pc_fs,
    output logic                    pc_in_sel,
    output logic [K_WIDTH-1:0]      k_out,
    output logic                    bus_conflict
);

    fsm_t                    fsm_reg, fsm_next;
    logic [CW_WIDTH-1:0]     cw_reg;
    logic [K_WIDTH-1:0]      k_reg;
    logic [1:0]              cu_state_reg;
    logic [STATUS_WIDTH-1:0] status_reg;
    logic                    bus_conflict_reg;
    logic                    cw_ready;
    logic                    accept;
    logic                    in_issue;
    logic                    in_conflict;
    cw_fields_t              fields;

    cw_field_split u_split (
        .cw     (cw_reg),
        .fields (fields)
    );

    always_comb begin
        fsm_next = fsm_reg;
        cw_ready = 1'b0;
        unique case (fsm_reg)
            IDLE: begin
                cw_ready = 1'b1;
                if (dec.cw_valid) fsm_next = ISSUE;
            end
            ISSUE: begin
                if (dp_stall) begin
                    fsm_next = STALL;
                end else begin
                    cw_ready = 1'b1;
                    fsm_next = dec.cw_valid ? ISSUE : IDLE;
                end
            end
            STALL: begin
                if (!dp_stall) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign accept      = dec.cw_valid && cw_ready;
    assign in_issue    = (fsm_reg == ISSUE);
    assign in_conflict = multi_bus_enable({dec.cw_in[CW_ALU_EN], dec.cw_in[CW_RF_B_EN],
                                           dec.cw_in[CW_RAM_EN], dec.cw_in[CW_PC_EN]});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_reg          <= IDLE;
            cw_reg           <= '0;
            k_reg            <= '0;
            cu_state_reg     <= CU_FETCH;
            status_reg       <= '0;
            bus_conflict_reg <= 1'b0;
        end else begin
            fsm_reg <= fsm_next;
            if (accept) begin
                cw_reg <= dec.cw_in;
                k_reg  <= dec.k_in;
                // Conflict is flagged at capture so the word's own writes are already blocked.
                if (in_conflict) bus_conflict_reg <= 1'b1;
            end
            if (in_issue) begin
                cu_state_reg <= fields.ns;
                if (fields.status_load && !bus_conflict_reg) status_reg <= alu_status;
            end
        end
    end

    assign dec.cw_ready = cw_ready;
    assign dec.state    = cu_state_reg;
    assign dec.status   = status_reg;

    assign alu_en       = fields.alu_en;
    assign alu_bs       = fields.alu_bs;
    assign alu_fs       = fields.alu_fs;
    assign rf_b_en      = fields.rf_b_en;
    assign rf_sa        = fields.sa;
    assign rf_sb        = fields.sb;
    assign rf_wa        = fields.wa;
    assign ram_en       = fields.ram_en;
    assign pc_en        = fields.pc_en;
    assign pc_fs        = fields.pc_fs;
    assign pc_in_sel    = fields.pc_in_sel;
    assign k_out        = k_reg;
    assign bus_conflict = bus_conflict_reg;

    // Writes fire only in the single ISSUE cycle of a conflict-free history.
    assign rf_w  = in_issue && fields.rf_w  && !bus_conflict_reg;
    assign ram_w = in_issue && fields.ram_w && !bus_conflict_reg;

endmodule

// File: tb/tb_control_word_dispatch.sv
// Randomized and directed checks of control_word_dispatch against a transaction-level model.
module tb_control_word_dispatch;
    import cu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        dp_stall;
    logic [4:0]  alu_status;
    logic        alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_en, pc_in_sel, bus_conflict;
    logic [4:0]  alu_fs, rf_sa, rf_sb, rf_wa;
    logic [1:0]  pc_fs;
    logic [63:0] k_out;

    int total = 0;
    int bad   = 0;

    // Model: last accepted word, whether it is being issued now, whether the datapath holds it.
    logic [32:0] m_word;
    logic [63:0] m_k;
    logic        m_fresh, m_stalled, m_conflict;
    logic [1:0]  m_state;
    logic [4:0]  m_status;

    control_word_dispatch_if dec();

    always #5 clock = ~clock;

    control_word_dispatch dut (
        .clock        (clock),
        .reset        (reset),
        .dec          (dec.slave),
        .dp_stall     (dp_stall),
        .alu_status   (alu_status),
        .alu_en       (alu_en),
        .alu_bs       (alu_bs),
        .alu_fs       (alu_fs),
        .rf_b_en      (rf_b_en),
        .rf_sa        (rf_sa),
        .rf_sb        (rf_sb),
        .rf_wa        (rf_wa),
        .rf_w         (rf_w),
        .ram_en       (ram_en),
        .ram_w        (ram_w),
        .pc_en        (pc_en),
        .pc_fs        (pc_fs),
        .pc_in_sel    (pc_in_sel),
        .k_out        (k_out),
        .bus_conflict (bus_conflict)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_word = '0; m_k = '0; m_fresh = 0; m_stalled = 0; m_conflict = 0;
        m_state = 2'b00; m_status = '0;
    endtask

    task automatic check_outputs();
        logic [27:0] ctrl_got, ctrl_exp;
        ctrl_got = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_wa,
                    ram_en, pc_en, pc_fs, pc_in_sel};
        ctrl_exp = {m_word[32:10], m_word[8], m_word[6:3]};
        check_val("ctrl", ctrl_got, ctrl_exp);
        check_val("rf_w", rf_w, m_fresh && m_word[9] && !m_conflict);
        check_val("ram_w", ram_w, m_fresh && m_word[7] && !m_conflict);
        check_val("k_out", k_out, m_k);
        check_val("state", dec.state, m_state);
        check_val("status", dec.status, m_status);
        check_val("bus_conflict", bus_conflict, m_conflict);
    endtask

    // One clock of stimulus: drive, check handshake, advance model over the edge, check outputs.
    task automatic step(input logic [32:0] cw, input logic [63:0] k, input logic v,
                        input logic st, input logic [4:0] as);
        logic ready_exp, acc;
        dec.cw_in = cw; dec.k_in = k; dec.cw_valid = v; dp_stall = st; alu_status = as;
        #1;
        ready_exp = !m_stalled && !(m_fresh && st);
        check_val("cw_ready", dec.cw_ready, ready_exp);
        acc = v && ready_exp;
        @(posedge clock);
        if (m_fresh) begin
            m_state = m_word[1:0];
            if (m_word[2] && !m_conflict) m_status = as;
        end
        m_stalled = (m_fresh || m_stalled) && st;
        m_fresh   = acc;
        if (acc) begin
            m_word = cw;
            m_k    = k;
            if ($countones({cw[32], cw[25], cw[8], cw[6]}) > 1) m_conflict = 1;
            $display("word accepted t=%0t cw=%h k=%h", $time, cw, k);
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [32:0] rand_word();
        logic [32:0] w;
        int          pick;
        w = {$urandom, $urandom};
        w[32] = 0; w[25] = 0; w[8] = 0; w[6] = 0;
        pick = $urandom_range(0, 4);
        case (pick)
            0: w[32] = 1;
            1: w[25] = 1;
            2: w[8]  = 1;
            3: w[6]  = 1;
            default: ;
        endcase
        return w;
    endfunction

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step(rand_word(), {$urandom, $urandom}, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0), 5'($urandom));
    endtask

    initial begin
        logic [32:0] w;
        int          ram_w_hits;

        reset = 1; dp_stall = 0; alu_status = 0;
        dec.cw_in = '0; dec.k_in = '0; dec.cw_valid = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 0;
        check_outputs();
        check_val("reset_ready", dec.cw_ready, 1'b1);

        // ADD-type word: visible one cycle after acceptance, strobe gone the cycle after.
        w = '0; w[32] = 1; w[30:26] = 5'b01000; w[24:20] = 5'd3; w[14:10] = 5'd5;
        w[9] = 1; w[5:4] = 2'b01; w[3] = 1;
        step(w, 64'h1234, 1, 0, 0);
        check_val("add_fs", alu_fs, 5'b01000);
        check_val("add_sa", rf_sa, 5'd3);
        check_val("add_wa", rf_wa, 5'd5);
        check_val("add_rf_w", rf_w, 1'b1);
        step('0, '0, 0, 0, 0);
        check_val("add_rf_w_off", rf_w, 1'b0);

        // Back-to-back words at full rate.
        w[14:10] = 5'd7;
        step(w, 64'h1, 1, 0, 0);
        w[14:10] = 5'd9;
        step(w, 64'h2, 1, 0, 0);
        check_val("b2b_wa", rf_wa, 5'd9);
        check_val("b2b_rf_w", rf_w, 1'b1);
        step('0, '0, 0, 0, 0);

        // Status load and hold.
        w = '0; w[32] = 1; w[2] = 1;
        step(w, 64'h0, 1, 0, 0);
        step('0, '0, 0, 0, 5'b10010);
        check_val("status_load", dec.status, 5'b10010);
        w[2] = 0;
        step(w, 64'h0, 1, 0, 5'b00111);
        step('0, '0, 0, 0, 5'b00111);
        check_val("status_hold", dec.status, 5'b10010);

        // Memory write held by a 3-cycle stall.
        w = '0; w[8] = 1; w[7] = 1;
        step(w, 64'h55, 1, 0, 0);
        ram_w_hits = int'(ram_w);
        step(rand_word(), 64'h66, 1, 1, 0);
        ram_w_hits += int'(ram_w);
        check_val("stall_ram_en", ram_en, 1'b1);
        step(rand_word(), 64'h77, 1, 1, 0);
        ram_w_hits += int'(ram_w);
        step('0, '0, 0, 0, 0);
        ram_w_hits += int'(ram_w);
        check_val("stall_ram_w_pulses", ram_w_hits, 1);
        check_val("stall_k_held", k_out, 64'h55);

        rand_steps(300);

        // Conflicting word: enables pass, writes suppressed, flag sticky.
        w = '0; w[32] = 1; w[8] = 1; w[9] = 1; w[7] = 1;
        step(w, 64'h99, 1, 0, 0);
        check_val("conf_flag", bus_conflict, 1'b1);
        check_val("conf_rf_w", rf_w, 1'b0);
        check_val("conf_ram_en", ram_en, 1'b1);
        rand_steps(30);
        check_val("conf_sticky", bus_conflict, 1'b1);

        // Reset during a stall.
        w = '0; w[8] = 1; w[1:0] = 2'b10;
        step(w, 64'hABCD, 1, 0, 0);
        step('0, '0, 0, 1, 0);
        check_val("ns_state", dec.state, 2'b10);
        reset = 1;
        #2;
        model_reset();
        check_outputs();
        check_val("rst_state", dec.state, 2'b00);
        @(posedge clock);
        #1 reset = 0; dp_stall = 0; dec.cw_valid = 0;
        #1;
        check_val("rst_ready", dec.cw_ready, 1'b1);
        rand_steps(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
